ru_unit: RTL and testbench
==========================

Name: ru_unit

Overview:
- Reconfigurable arithmetic unit inside the nonlinear-function datapath (exp/GELU/normalisation pipelines).
- Multiplies a selected signed fixed-point operand by one of eight built-in constants.
- Then either splits the product into integer/fraction parts (exp2 decomposition), or forms a sum/difference pair with in0.
- Single registered stage.

Parameters:
- Bf, 8, number of fractional bits of the fixed-point format (1 <= Bf <= FIX_POINT_WIDTH-2)
- FIX_POINT_WIDTH, 16, total width of every data port; signed two's complement, Q(W-Bf).Bf

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- in0  input  FIX_POINT_WIDTH  signed fixed-point operand A
- in1  input  FIX_POINT_WIDTH  signed fixed-point operand B
- s_mux  input  1  mode select: 0 = decompose, 1 = add/sub
- s_mult  input  3  constant select K
- u  output  FIX_POINT_WIDTH  registered scaled product
- out0  output  FIX_POINT_WIDTH  registered result 0
- out1  output  FIX_POINT_WIDTH  registered result 1

Behaviour:
- One clock domain (clk); reset is synchronous and active-low: rst=0 sampled at a rising edge sets u, out0, out1 to 0 at that edge; takes priority over everything, including mid-operation.
- Latency 1 cycle: inputs sampled at edge N, results visible after edge N. No handshake; a new operation is accepted every cycle.
- Constant K, stored as KQ = round(K*2^Bf), signed W-bit, computed at elaboration:
  - s_mult=0: 1.0
  - s_mult=1: log2(e)=1.442695 (Bf=8: 0x0171)
  - s_mult=2: ln2=0.693147 (0x00B1)
  - s_mult=3: 1/sqrt(2)=0.707107 (0x00B5)
  - s_mult=4: sqrt(2/pi)=0.797885 (0x00CC)
  - s_mult=5: 0.5 (0x0080)
  - s_mult=6: 0.044715 (0x000B)
  - s_mult=7: -1.0 (0xFF00)
- Operand X = (s_mux ? in1 : in0).
- P = X*KQ, full 2W-bit signed. Ps = (P + 2^(Bf-1)) >>> Bf (arithmetic shift, round half up). u_next = Ps clamped to [-2^(W-1), 2^(W-1)-1]. The product is always saturated, independent of the macro below.
- s_mux=0 (decompose):
  - out0 = u_next >>> Bf, i.e. floor integer part as a plain signed integer, sign-extended.
  - out1 = u_next & (2^Bf-1), i.e. non-negative fraction, upper bits zero.
  - Invariant: u = out0*2^Bf + out1.
- s_mux=1 (add/sub): out0 = in0 + u_next, out1 = in0 - u_next, both computed at W+1 bits, then reduced to W bits per the optional feature.
- All arithmetic is signed; no X propagation from unused operands.

Optional Feature:
- Macro RU_SAT_EN.
- Defined: add/sub results in s_mux=1 are clamped to [0x8000, 0x7FFF] (W=16) on overflow.
- Undefined: those results wrap, keeping the low W bits of the W+1-bit sum.
- The decompose mode and u are identical in both builds.

Test Plan:
- Decompose, log2(e): s_mux=0, s_mult=1, in0=0x0400 (4.0) -> one cycle later u=0x05C4, out0=0x0005, out1=0x00C4.
- Negative floor: s_mux=0, s_mult=0, in0=0xFE80 (-1.5) -> u=0xFE80, out0=0xFFFE, out1=0x0080.
- Add/sub: s_mux=1, s_mult=5, in0=0x0100, in1=0x0400 -> u=0x0200, out0=0x0300, out1=0xFF00.
- Product saturation: s_mux=0, s_mult=1, in0=0x7000 -> u=0x7FFF, out0=0x007F, out1=0x00FF.
- Sum overflow: s_mux=1, s_mult=0, in0=in1=0x7F00 -> u=0x7F00, out1=0x0000; out0=0x7FFF with RU_SAT_EN, 0xFE00 without.
- Reset: drive any nonzero case, then assert rst=0 for one edge -> u, out0, out1 = 0 after that edge; release rst -> results resume with 1-cycle latency. Also check that rst=0 asserted between edges has no effect until the next edge.

Source files
------------

// File: rtl/ru_unit.sv
// rtl/ru_unit.sv - constant-multiply unit with exp2 decompose or add/sub, one registered stage
// Build option RU_SAT_EN: saturate add/sub results instead of wrapping.
module ru_unit #(
  parameter int Bf              = 8,
  parameter int FIX_POINT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FIX_POINT_WIDTH-1:0] in0,
  input  logic [FIX_POINT_WIDTH-1:0] in1,
  input  logic                       s_mux,
  input  logic [2:0]                 s_mult,
  output logic [FIX_POINT_WIDTH-1:0] u,
  output logic [FIX_POINT_WIDTH-1:0] out0,
  output logic [FIX_POINT_WIDTH-1:0] out1
);

  localparam int W = FIX_POINT_WIDTH;

  // Round-to-nearest fixed-point encoding of a real constant, evaluated at elaboration.
  function automatic logic signed [W-1:0] to_fix(input real k);
    real s;
    s = k * (2.0 ** Bf);
    if (s >= 0.0) return W'($rtoi(s + 0.5));
    else          return W'(-$rtoi(-s + 0.5));
  endfunction

  localparam logic signed [W-1:0] K0 = to_fix(1.0);
  localparam logic signed [W-1:0] K1 = to_fix(1.4426950408889634);
  localparam logic signed [W-1:0] K2 = to_fix(0.6931471805599453);
  localparam logic signed [W-1:0] K3 = to_fix(0.7071067811865476);
  localparam logic signed [W-1:0] K4 = to_fix(0.7978845608028654);
  localparam logic signed [W-1:0] K5 = to_fix(0.5);
  localparam logic signed [W-1:0] K6 = to_fix(0.044715);
  localparam logic signed [W-1:0] K7 = to_fix(-1.0);

  localparam logic signed [2*W-1:0] RND  = {{(2*W-1){1'b0}}, 1'b1} << (Bf - 1);
  localparam logic signed [2*W-1:0] PMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] PMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]          FRAC_MASK = {{(W-Bf){1'b0}}, {Bf{1'b1}}};

  // Narrow a W+1-bit add/sub result to W bits.
  function automatic logic [W-1:0] reduce(input logic [W:0] v);
`ifdef RU_SAT_EN
    if (v[W] != v[W-1]) return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return v[W-1:0];
`else
    return v[W-1:0];
`endif
  endfunction

  logic signed [W-1:0]   kq;
  logic signed [W-1:0]   x;
  logic signed [2*W-1:0] p;
  logic signed [2*W-1:0] ps_full;
  logic signed [W-1:0]   u_next;
  logic [W:0]            sum;
  logic [W:0]            dif;
  logic [W-1:0]          out0_next;
  logic [W-1:0]          out1_next;

  always_comb begin
    kq        = K0;
    x         = '0;
    p         = '0;
    ps_full   = '0;
    u_next    = '0;
    sum       = '0;
    dif       = '0;
    out0_next = '0;
    out1_next = '0;

    case (s_mult)
      3'd0:    kq = K0;
      3'd1:    kq = K1;
      3'd2:    kq = K2;
      3'd3:    kq = K3;
      3'd4:    kq = K4;
      3'd5:    kq = K5;
      3'd6:    kq = K6;
      default: kq = K7;
    endcase

    x       = s_mux ? in1 : in0;
    p       = $signed({{W{x[W-1]}}, x}) * $signed({{W{kq[W-1]}}, kq});
    ps_full = (p + RND) >>> Bf;

    if (ps_full > PMAX)      u_next = PMAX[W-1:0];
    else if (ps_full < PMIN) u_next = PMIN[W-1:0];
    else                     u_next = ps_full[W-1:0];

    sum = {in0[W-1], in0} + {u_next[W-1], u_next};
    dif = {in0[W-1], in0} - {u_next[W-1], u_next};

    if (s_mux) begin
      out0_next = reduce(sum);
      out1_next = reduce(dif);
    end else begin
      // Floor integer part plus non-negative fraction, so u = out0*2^Bf + out1.
      out0_next = u_next >>> Bf;
      out1_next = u_next & FRAC_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      u    <= '0;
      out0 <= '0;
      out1 <= '0;
    end else begin
      u    <= u_next;
      out0 <= out0_next;
      out1 <= out1_next;
    end
  end

endmodule

// File: tb/tb_ru_unit.sv
// tb/tb_ru_unit.sv - directed self-checking bench for ru_unit
module tb_ru_unit;

  logic        clk;
  logic        rst;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        s_mux;
  logic [2:0]  s_mult;
  logic [15:0] u;
  logic [15:0] out0;
  logic [15:0] out1;

  int errors = 0;
  int checks = 0;

  ru_unit #(.Bf(8), .FIX_POINT_WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .in0    (in0),
    .in1    (in1),
    .s_mux  (s_mux),
    .s_mult (s_mult),
    .u      (u),
    .out0   (out0),
    .out1   (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic m, input logic [2:0] k, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    s_mux  = m;
    s_mult = k;
    in0    = a;
    in1    = b;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 3'd0, 16'h1234, 16'h4321);
    edge_settle();
    checks++;
    if ({u, out0, out1} !== 48'h0) begin
      errors++;
      $display("FAIL reset_state: u=%h out0=%h out1=%h required 0000 0000 0000", u, out0, out1);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_decompose();
    logic [2:0]  k  [5] = '{3'd1,     3'd0,     3'd5,     3'd5,     3'd6};
    logic [15:0] a  [5] = '{16'h0400, 16'hFE80, 16'hFFFF, 16'hFFFD, 16'h0A00};
    logic [15:0] eu [5] = '{16'h05C4, 16'hFE80, 16'h0000, 16'hFFFF, 16'h006E};
    logic [15:0] e0 [5] = '{16'h0005, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h0000};
    logic [15:0] e1 [5] = '{16'h00C4, 16'h0080, 16'h0000, 16'h00FF, 16'h006E};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, k[i], a[i], 16'hAAAA);
      edge_settle();
      checks++;
      if ({u, out0, out1} !== {eu[i], e0[i], e1[i]}) begin
        errors++;
        $display("FAIL decompose[%0d]: u=%h out0=%h out1=%h required %h %h %h",
                 i, u, out0, out1, eu[i], e0[i], e1[i]);
      end
    end
  endtask

  task automatic test_addsub();
    logic [2:0]  k  [2] = '{3'd5,     3'd2};
    logic [15:0] a  [2] = '{16'h0100, 16'h0080};
    logic [15:0] b  [2] = '{16'h0400, 16'h0100};
    logic [15:0] eu [2] = '{16'h0200, 16'h00B1};
    logic [15:0] e0 [2] = '{16'h0300, 16'h0131};
    logic [15:0] e1 [2] = '{16'hFF00, 16'hFFCF};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, k[i], a[i], b[i]);
      edge_settle();
      checks++;
      if ({u, out0, out1} !== {eu[i], e0[i], e1[i]}) begin
        errors++;
        $display("FAIL addsub[%0d]: u=%h out0=%h out1=%h required %h %h %h",
                 i, u, out0, out1, eu[i], e0[i], e1[i]);
      end
    end
  endtask

  task automatic test_product_saturation();
    drive(1'b0, 3'd1, 16'h7000, 16'h0000);
    edge_settle();
    checks++;
    if ({u, out0, out1} !== {16'h7FFF, 16'h007F, 16'h00FF}) begin
      errors++;
      $display("FAIL sat_pos: u=%h out0=%h out1=%h required 7fff 007f 00ff", u, out0, out1);
    end
    drive(1'b0, 3'd7, 16'h8000, 16'h0000);
    edge_settle();
    checks++;
    if ({u, out0, out1} !== {16'h7FFF, 16'h007F, 16'h00FF}) begin
      errors++;
      $display("FAIL sat_neg_times_neg: u=%h out0=%h out1=%h required 7fff 007f 00ff", u, out0, out1);
    end
  endtask

  task automatic test_sum_overflow();
    logic [15:0] e_pos;
    logic [15:0] e_neg;
`ifdef RU_SAT_EN
    e_pos = 16'h7FFF;
    e_neg = 16'h8000;
`else
    e_pos = 16'hFE00;
    e_neg = 16'h7F00;
`endif
    drive(1'b1, 3'd0, 16'h7F00, 16'h7F00);
    edge_settle();
    checks++;
    if ({u, out0, out1} !== {16'h7F00, e_pos, 16'h0000}) begin
      errors++;
      $display("FAIL overflow_pos: u=%h out0=%h out1=%h required 7f00 %h 0000", u, out0, out1, e_pos);
    end
    drive(1'b1, 3'd7, 16'h8000, 16'h0100);
    edge_settle();
    checks++;
    if ({u, out0, out1} !== {16'hFF00, e_neg, 16'h8100}) begin
      errors++;
      $display("FAIL overflow_neg: u=%h out0=%h out1=%h required ff00 %h 8100", u, out0, out1, e_neg);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 3'd1, 16'h0400, 16'h0000);
    @(posedge clk);
    #1;
    s_mux  = 1'b1;
    s_mult = 3'd5;
    in0    = 16'h0100;
    in1    = 16'h0400;
    #2;
    checks++;
    if ({u, out0, out1} !== {16'h05C4, 16'h0005, 16'h00C4}) begin
      errors++;
      $display("FAIL b2b_first: u=%h out0=%h out1=%h required 05c4 0005 00c4", u, out0, out1);
    end
    edge_settle();
    checks++;
    if ({u, out0, out1} !== {16'h0200, 16'h0300, 16'hFF00}) begin
      errors++;
      $display("FAIL b2b_second: u=%h out0=%h out1=%h required 0200 0300 ff00", u, out0, out1);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 3'd0, 16'hFE80, 16'h0000);
    edge_settle();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({u, out0, out1} !== {16'hFE80, 16'hFFFE, 16'h0080}) begin
      errors++;
      $display("FAIL reset_between_edges: u=%h out0=%h out1=%h required fe80 fffe 0080", u, out0, out1);
    end
    edge_settle();
    checks++;
    if ({u, out0, out1} !== 48'h0) begin
      errors++;
      $display("FAIL reset_midstream: u=%h out0=%h out1=%h required 0000 0000 0000", u, out0, out1);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 3'd5, 16'h0100, 16'h0400);
    edge_settle();
    checks++;
    if ({u, out0, out1} !== {16'h0200, 16'h0300, 16'hFF00}) begin
      errors++;
      $display("FAIL reset_resume: u=%h out0=%h out1=%h required 0200 0300 ff00", u, out0, out1);
    end
  endtask

  initial begin
    rst    = 1'b0;
    s_mux  = 1'b0;
    s_mult = 3'd0;
    in0    = 16'h0000;
    in1    = 16'h0000;
    test_reset();
    test_decompose();
    test_addsub();
    test_product_saturation();
    test_sum_overflow();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
